// File: rtl/capp_pkg.sv
// Shared CAPP definitions: host opcodes, whitespace bytes, command receiver state
// encoding and a classifier used by both the receiver and the sequencer.
package capp_pkg;

  localparam int unsigned NUM_BYTES_DEF = 4;

  localparam logic [7:0] OP_SET_COMPARAND = 8'h61;  // 'a'
  localparam logic [7:0] OP_GET_COMPARAND = 8'h62;  // 'b'
  localparam logic [7:0] OP_SET_MASK      = 8'h63;  // 'c'
  localparam logic [7:0] OP_GET_MASK      = 8'h64;  // 'd'
  localparam logic [7:0] OP_WRITE         = 8'h65;  // 'e'
  localparam logic [7:0] OP_READ          = 8'h66;  // 'f'
  localparam logic [7:0] OP_CLEAR         = 8'h67;  // 'g'
  localparam logic [7:0] OP_SET_TAG       = 8'h68;  // 'h'
  localparam logic [7:0] OP_CLR_TAG       = 8'h69;  // 'i'
  localparam logic [7:0] OP_STATUS        = 8'h6A;  // 'j'
  localparam logic [7:0] OP_SEARCH        = 8'h6B;  // 'k'

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {
    WAIT_OP   = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2
  } cmd_rx_state_t;

  typedef enum logic [1:0] {
    OPC_PAYLOAD,
    OPC_PLAIN,
    OPC_IGNORE,
    OPC_BAD
  } op_class_t;

  function automatic op_class_t classify_op(input logic [7:0] b);
    op_class_t c;
    case (b)
      OP_SET_COMPARAND, OP_SET_MASK:                  c = OPC_PAYLOAD;
      OP_GET_COMPARAND, OP_GET_MASK, OP_WRITE, OP_READ,
      OP_CLEAR, OP_SET_TAG, OP_CLR_TAG, OP_STATUS,
      OP_SEARCH:                                      c = OPC_PLAIN;
      CH_LF, CH_CR, CH_SP:                            c = OPC_IGNORE;
      default:                                        c = OPC_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/capp_cmd_rx_if.sv
// Byte-stream input, command output and error reporting of capp_cmd_rx.
// master = receiver side, slave = host/sequencer side.
interface capp_cmd_rx_if #(
  parameter int unsigned NUM_BYTES = capp_pkg::NUM_BYTES_DEF
);
  logic [7:0]             uart_out_data;
  logic                   uart_out_valid;
  logic                   uart_out_ready;
  logic [7:0]             cmd_op;
  logic [8*NUM_BYTES-1:0] cmd_word;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   err_pulse;
  logic [7:0]             err_cnt;

  modport master (
    input  uart_out_data, uart_out_valid, cmd_ready,
    output uart_out_ready, cmd_op, cmd_word, cmd_valid, err_pulse, err_cnt
  );

  modport slave (
    output uart_out_data, uart_out_valid, cmd_ready,
    input  uart_out_ready, cmd_op, cmd_word, cmd_valid, err_pulse, err_cnt
  );
endinterface

// File: rtl/capp_cmd_rx.sv
// CAPP command receiver: decodes host opcodes, assembles little-endian payloads.
// Define CAPP_CMD_RX_TIMEOUT_EN to enable the inter-byte timeout abort.
module capp_cmd_rx
  import capp_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = NUM_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input logic           clk_48mhz,
  input logic           reset_n,
  capp_cmd_rx_if.master bus
);
  localparam int unsigned NUM_BITS = 8 * NUM_BYTES;
  localparam int unsigned IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 24'hFFFFFF) begin : g_bad_timeout
    $error("capp_cmd_rx: TIMEOUT_CYCLES out of range");
  end

  cmd_rx_state_t       state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                accept;
  logic                timeout;

  assign accept = bus.uart_out_valid && rdy_q;

`ifdef CAPP_CMD_RX_TIMEOUT_EN
  localparam int unsigned TMR_W = 24;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Abort fires on the idle cycle that would bring the count to TIMEOUT_CYCLES;
  // an accepted byte in that cycle takes priority.
  assign timeout = (state_q == WAIT_DATA) && !accept && (tmr_q == TMR_LAST);

  always_comb begin
    tmr_d = tmr_q + 1'b1;
    if (state_q != WAIT_DATA || accept || timeout) tmr_d = '0;
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) tmr_q <= '0;
    else          tmr_q <= tmr_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_OP: begin
        if (accept) begin
          unique case (classify_op(bus.uart_out_data))
            OPC_PAYLOAD: begin
              op_d    = bus.uart_out_data;
              word_d  = '0;
              idx_d   = '0;
              state_d = WAIT_DATA;
            end
            OPC_PLAIN: begin
              op_d    = bus.uart_out_data;
              word_d  = '0;
              state_d = HOLD;
            end
            OPC_BAD:    err_d = 1'b1;
            OPC_IGNORE: ;
          endcase
        end
      end
      WAIT_DATA: begin
        if (accept) begin
          word_d[8*idx_q +: 8] = bus.uart_out_data;
          idx_d                = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = HOLD;
          end
        end else if (timeout) begin
          word_d  = '0;
          idx_d   = '0;
          err_d   = 1'b1;
          state_d = WAIT_OP;
        end
      end
      HOLD: begin
        if (bus.cmd_ready) state_d = WAIT_OP;
      end
      default: state_d = WAIT_OP;
    endcase
    if (err_d && cnt_q != 8'hFF) cnt_d = cnt_q + 1'b1;
    rdy_d = (state_d != HOLD);
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_OP;
      op_q    <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.uart_out_ready = rdy_q;
  assign bus.cmd_valid      = (state_q == HOLD);
  assign bus.cmd_op         = op_q;
  assign bus.cmd_word       = word_q;
  assign bus.err_pulse      = err_q;
  assign bus.err_cnt        = cnt_q;

endmodule

// File: tb/tb_capp_cmd_rx.sv
// Self-checking bench for capp_cmd_rx: vector table plus hand-written corner sequences,
// with a scoreboard of expected commands popped on each cmd handshake.
module tb_capp_cmd_rx;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] word;
  } cmd_t;

  typedef struct {
    logic [7:0]  op;
    bit          pay;
    logic [31:0] word;
    bit          cmd;
    bit          err;
  } vec_t;

  logic clk;
  logic rst_n;

  capp_cmd_rx_if #(.NUM_BYTES(4)) bus ();

  capp_cmd_rx #(
    .NUM_BYTES      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_48mhz (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  cmd_t        sb[$];
  vec_t        vecs[17];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned err_model = 0;
  int unsigned exp_pulses = 0;
  int unsigned pulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_err();
    if (err_model < 255) err_model++;
    exp_pulses++;
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    bus.uart_out_data  = b;
    bus.uart_out_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.uart_out_ready) break;
    end
    if (n == 100) check("uart_ready_wait", bus.uart_out_ready, 1);
    @(posedge clk);
    #1;
    bus.uart_out_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic hold_check(input logic [7:0] op, input logic [31:0] w, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check("hold_valid", bus.cmd_valid, 1);
      check("hold_ready_low", bus.uart_out_ready, 0);
      check("hold_op", bus.cmd_op, op);
      check("hold_word", bus.cmd_word, w);
    end
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b1;
  endtask

  task automatic settle_and_check(input string tag);
    wait_cycles(3);
    check({tag, "_err_cnt"}, bus.err_cnt, err_model);
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_pulse) pulses++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        check("sb_has_entry", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cmd_t e;
          e = sb.pop_front();
          check("sb_cmd_op", bus.cmd_op, e.op);
          check("sb_cmd_word", bus.cmd_word, e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.cmd_ready      = 1'b1;
    bus.uart_out_valid = 1'b0;
    bus.uart_out_data  = '0;

    #22;
    check("rst_ready", bus.uart_out_ready, 0);
    check("rst_valid", bus.cmd_valid, 0);
    check("rst_op", bus.cmd_op, 0);
    check("rst_word", bus.cmd_word, 0);
    check("rst_err_pulse", bus.err_pulse, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
    check("ready_after_reset", bus.uart_out_ready, 1);

    vecs[0]  = '{8'h61, 1'b1, 32'h12345678, 1'b1, 1'b0};
    vecs[1]  = '{8'h63, 1'b1, 32'hA50A0D20, 1'b1, 1'b0};
    vecs[2]  = '{8'h62, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[3]  = '{8'h64, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[4]  = '{8'h65, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{8'h66, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[6]  = '{8'h67, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[7]  = '{8'h68, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[8]  = '{8'h69, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{8'h6A, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[10] = '{8'h6B, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{8'h0A, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{8'h0D, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{8'h20, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[14] = '{8'h00, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[15] = '{8'h41, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[16] = '{8'h6C, 1'b0, 32'h0, 1'b0, 1'b1};

    foreach (vecs[i]) begin
      send_byte(vecs[i].op);
      if (vecs[i].pay) send_word(vecs[i].word);
      if (vecs[i].cmd) sb.push_back({vecs[i].op, vecs[i].word});
      if (vecs[i].err) note_err();
      settle_and_check("vec");
    end

    // Payload command held by the sequencer: input side must stall.
    bus.cmd_ready = 1'b0;
    send_byte(8'h61);
    send_word(32'h12345678);
    sb.push_back({8'h61, 32'h12345678});
    hold_check(8'h61, 32'h12345678, 3);
    settle_and_check("hold_a");

    bus.cmd_ready = 1'b0;
    send_byte(8'h66);
    sb.push_back({8'h66, 32'h0});
    hold_check(8'h66, 32'h0, 10);
    settle_and_check("hold_f");
    check("hold_f_valid_drop", bus.cmd_valid, 0);

    send_byte(8'h7A);
    note_err();
    wait_cycles(3);
    check("z_err_cnt", bus.err_cnt, err_model);
    check("z_pulses", pulses, exp_pulses);
    send_byte(8'h0D);
    settle_and_check("cr");
    send_byte(8'h62);
    sb.push_back({8'h62, 32'h0});
    settle_and_check("after_z");

`ifdef CAPP_CMD_RX_TIMEOUT_EN
    send_byte(8'h63);
    send_byte(8'hFF);
    wait_cycles(TO);
    note_err();
    wait_cycles(2);
    check("to_valid", bus.cmd_valid, 0);
    check("to_err_cnt", bus.err_cnt, err_model);
    check("to_pulses", pulses, exp_pulses);
    send_byte(8'h62);
    sb.push_back({8'h62, 32'h0});
    settle_and_check("after_to");

    send_byte(8'h63);
    send_byte(8'h11);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    sb.push_back({8'h63, 32'h44332211});
    settle_and_check("to_edge");
`else
    send_byte(8'h63);
    send_byte(8'hFF);
    wait_cycles(200);
    check("noto_valid", bus.cmd_valid, 0);
    check("noto_err_cnt", bus.err_cnt, err_model);
    send_byte(8'hEE);
    send_byte(8'hDD);
    send_byte(8'hCC);
    sb.push_back({8'h63, 32'hCCDDEEFF});
    settle_and_check("noto");
`endif

    for (int unsigned i = 0; i < 300; i++) begin
      send_byte(8'hFF);
      note_err();
    end
    settle_and_check("sat");
    check("sat_cnt_255", bus.err_cnt, 8'hFF);

    // Asynchronous reset mid-payload.
    send_byte(8'h61);
    send_byte(8'h01);
    send_byte(8'h02);
    #3;
    rst_n = 1'b0;
    #1;
    err_model = 0;
    check("mid_rst_ready", bus.uart_out_ready, 0);
    check("mid_rst_valid", bus.cmd_valid, 0);
    check("mid_rst_op", bus.cmd_op, 0);
    check("mid_rst_word", bus.cmd_word, 0);
    check("mid_rst_err_pulse", bus.err_pulse, 0);
    check("mid_rst_err_cnt", bus.err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
    send_byte(8'h61);
    send_word(32'hDEADBEEF);
    sb.push_back({8'h61, 32'hDEADBEEF});
    settle_and_check("post_rst");

    // Asynchronous reset while a command is held.
    bus.cmd_ready = 1'b0;
    send_byte(8'h6B);
    wait_cycles(2);
    check("hold_rst_pre_valid", bus.cmd_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("hold_rst_valid", bus.cmd_valid, 0);
    check("hold_rst_op", bus.cmd_op, 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.cmd_ready = 1'b1;
    wait_cycles(2);
    send_byte(8'h65);
    sb.push_back({8'h65, 32'h0});
    settle_and_check("post_hold_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/capp_cmd_rx.md
# capp_cmd_rx

Command receiver between `usb_uart` byte output and the CAPP control sequencer. Consumes the USB-UART out stream, decodes single-character opcodes, assembles the 32-bit little-endian payload for opcodes that carry one, and presents one complete command per handshake to the sequencer. Inter-byte timeout recovery and an error counter make a dropped or garbled host byte self-healing instead of wedging the control path.

## Interface

- `NUM_BYTES`, 4: payload bytes per word; multiple-of-8 width rule holds, so `NUM_BITS = 8*NUM_BYTES`.
- `TIMEOUT_CYCLES`, 48000: inter-byte timeout in `clk_48mhz` cycles (1 ms); legal range 2..2^24-1.

- `clk_48mhz` input 1: sole clock.
- `reset_n` input 1: **one clock; reset is asynchronous and active-low**.
- `uart_out_data` input 8: received byte from `usb_uart`.
- `uart_out_valid` input 1: byte valid.
- `uart_out_ready` output 1: byte accepted when `uart_out_valid && uart_out_ready`.
- `cmd_op` output 8: decoded opcode byte ('a'..'k').
- `cmd_word` output NUM_BITS: payload; 0 for opcodes without payload.
- `cmd_valid` output 1: command available.
- `cmd_ready` input 1: sequencer takes command when `cmd_valid && cmd_ready`.
- `err_pulse` output 1: one-cycle strobe per unknown opcode or timeout abort.
- `err_cnt` output 8: saturating error count.

## Operation

- States: `WAIT_OP`, `WAIT_DATA`, `HOLD`.
- Reset values: state `WAIT_OP`, `uart_out_ready` 0 during reset then 1, `cmd_valid` 0, `cmd_op` 0, `cmd_word` 0, `err_pulse` 0, `err_cnt` 0, byte index 0, timer 0.
- `WAIT_OP`, byte accepted:
  - 'a' (set comparand) or 'c' (set mask): latch op, clear word, index 0, timer 0, go `WAIT_DATA`.
  - 'b','d','e','f','g','h','i','j','k': latch op, `cmd_word`=0, go `HOLD`.
  - 0x0A, 0x0D, 0x20: discarded silently, stay.
  - anything else: discarded, `err_pulse`, `err_cnt`+1 (saturate 255), stay.
- `WAIT_DATA`, byte accepted: write to `cmd_word[8*index +: 8]` (first byte = LSB); index+1; timer cleared. Accepting byte index `NUM_BYTES-1` moves to `HOLD`, index 0. Payload bytes are never decoded (0x0A is data here).
- `HOLD`: `cmd_valid`=1, `uart_out_ready`=0; on `cmd_ready` return to `WAIT_OP`, `cmd_valid`=0 next cycle. `cmd_op`/`cmd_word` stable while `cmd_valid`.
- Timeout (WAIT_DATA only): timer increments each cycle no byte is accepted; on reaching `TIMEOUT_CYCLES` → `WAIT_OP`, partial word dropped, `err_pulse`, `err_cnt`+1.

## Timing

- `uart_out_ready` is registered: 1 in `WAIT_OP`/`WAIT_DATA`, 0 in `HOLD`; no combinational path from `cmd_ready` or `uart_out_valid`.
- One byte per cycle max sustained throughput.
- `cmd_valid` rises the cycle after the final byte (opcode or last payload byte) is accepted.
- Back-to-back: `cmd_ready` high in first `HOLD` cycle → `uart_out_ready` 1 next cycle; next opcode accepted earliest 2 cycles after the final byte of the previous command.
- Byte accepted in the same cycle the timer would hit `TIMEOUT_CYCLES`: byte wins, timer clears, no error.
- `err_pulse` exactly one cycle, registered; at 255 `err_cnt` holds, `err_pulse` still fires.
- `reset_n` asserted mid-payload or in `HOLD`: all state cleared asynchronously; partial command lost, no `err_pulse`.

## Configuration

- `CAPP_CMD_RX_TIMEOUT_EN` defined: timer and timeout abort present as above.
- Undefined: no timer logic; `WAIT_DATA` waits indefinitely; `err_pulse`/`err_cnt` report unknown opcodes only; `TIMEOUT_CYCLES` ignored.

## Structure

- Shared `capp_pkg`: opcode constants (`OP_SET_COMPARAND`='a' … `OP_SEARCH`='k'), whitespace byte constants, state enum `cmd_rx_state_t`, `NUM_BYTES` default.
- The sequencer decodes opcodes from the same `capp_pkg` constants.
- Single flat module; no sub-module warranted (timer is one counter and compare).

## Test plan

- Send 'a',0x78,0x56,0x34,0x12 → `cmd_valid` with `cmd_op`=0x61, `cmd_word`=0x12345678; `uart_out_ready` low until `cmd_ready`.
- Send 'f' with `cmd_ready` held low 10 cycles → `cmd_valid` held 10 cycles, op 0x66, word 0; no further bytes accepted until handshake.
- Send 'z', then 0x0D → one `err_pulse`, `err_cnt`=1 after 'z'; 0x0D no error; state stays `WAIT_OP`.
- (`CAPP_CMD_RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16) 'c',0xFF then idle 16 cycles → abort, `err_cnt`+1, no `cmd_valid`; following 'b' yields op 0x62.
- Byte arriving exactly on timeout cycle → accepted, no error; reset_n low after 2 payload bytes → all outputs at reset values, next 'a'+4 bytes decode correctly.
- 300 unknown opcodes → `err_cnt` saturates at 255, 300 `err_pulse` strobes.
